// File: rtl/clic_pkg.sv
// Shared types for the CLIC interrupt transmitter.
// CLIC_IRQ_PRIV_EN: when defined, privilege mode takes precedence over level in arbitration.
package clic_pkg;

    localparam int unsigned MaxIdW    = 10;
    localparam int unsigned MaxLevelW = 16;

    localparam logic [1:0] PRIV_M = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        KILL = 2'd2
    } clic_state_e;

    typedef struct packed {
        logic [MaxIdW-1:0]    id;
        logic [MaxLevelW-1:0] level;
        logic                 shv;
        logic [1:0]           priv;
    } clic_req_t;

    // True when a ranks at least as high as b (the caller resolves ties toward lower ids).
    function automatic logic outranks(input clic_req_t a, input clic_req_t b);
`ifdef CLIC_IRQ_PRIV_EN
        return (a.priv > b.priv) || ((a.priv == b.priv) && (a.level >= b.level));
`else
        return a.level >= b.level;
`endif
    endfunction

endpackage

// File: rtl/clic_irq_arb.sv
// Combinational max tree choosing the best eligible interrupt source.
// CLIC_IRQ_PRIV_EN: when defined, per-source mode is compared ahead of level.
module clic_irq_arb
    import clic_pkg::*;
#(
    parameter int unsigned NumIrq = 64,
    parameter int unsigned LevelW = 8
) (
    input  logic [NumIrq-1:0]        pending,
    input  logic [NumIrq-1:0]        enable,
    input  logic [NumIrq*LevelW-1:0] level,
    input  logic [NumIrq-1:0]        shv,
    input  logic [NumIrq*2-1:0]      mode,
    input  logic [LevelW-1:0]        thresh,
    output logic [NumIrq-1:0]        elig,
    output logic                     best_valid,
    output clic_req_t                best
);

    localparam int unsigned Depth  = $clog2(NumIrq);
    localparam int unsigned Leaves = 1 << Depth;
    localparam int unsigned Nodes  = 2 * Leaves - 1;

    logic [Nodes-1:0]  node_v;
    clic_req_t         node_r [Nodes];
    logic [LevelW-1:0] lvl;
    logic              take_left;

`ifndef CLIC_IRQ_PRIV_EN
    logic unused_mode;
    assign unused_mode = ^mode;
`endif

    // Heap-ordered tree: leaves hold sources in id order, so preferring the left child on ties favours the lower id.
    always_comb begin
        node_v    = '0;
        elig      = '0;
        lvl       = '0;
        take_left = 1'b0;
        for (int n = 0; n < int'(Nodes); n++) begin
            node_r[n] = '0;
        end
        for (int k = 0; k < int'(NumIrq); k++) begin
            lvl                             = level[k*LevelW +: LevelW];
            elig[k]                         = pending[k] & enable[k] & (lvl > thresh);
            node_v[int'(Leaves) - 1 + k]    = elig[k];
            node_r[int'(Leaves) - 1 + k].id    = MaxIdW'(k);
            node_r[int'(Leaves) - 1 + k].level = MaxLevelW'(lvl);
            node_r[int'(Leaves) - 1 + k].shv   = shv[k];
`ifdef CLIC_IRQ_PRIV_EN
            node_r[int'(Leaves) - 1 + k].priv  = mode[k*2 +: 2];
`else
            node_r[int'(Leaves) - 1 + k].priv  = PRIV_M;
`endif
        end
        for (int i = int'(Leaves) - 2; i >= 0; i--) begin
            take_left = node_v[2*i+1] &
                        (!node_v[2*i+2] || outranks(node_r[2*i+1], node_r[2*i+2]));
            node_v[i] = node_v[2*i+1] | node_v[2*i+2];
            node_r[i] = take_left ? node_r[2*i+1] : node_r[2*i+2];
        end
    end

    assign best_valid = node_v[0];
    assign best       = node_r[0];

endmodule

// File: rtl/clic_irq_tx.sv
// CLIC interrupt transmitter: presents the best source to the core and retracts stale requests.
// CLIC_IRQ_PRIV_EN: when defined, arbitration and irq_priv_o follow per-source privilege mode.
module clic_irq_tx
    import clic_pkg::*;
#(
    parameter int unsigned NumIrq = 64,
    parameter int unsigned LevelW = 8,
    parameter int unsigned IdW    = $clog2(NumIrq)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NumIrq-1:0]        irq_pending_i,
    input  logic [NumIrq-1:0]        irq_enable_i,
    input  logic [NumIrq*LevelW-1:0] irq_level_i,
    input  logic [NumIrq-1:0]        irq_shv_i,
    input  logic [NumIrq-1:0]        irq_edge_i,
    input  logic [NumIrq*2-1:0]      irq_mode_i,
    input  logic [LevelW-1:0]        irq_thresh_i,
    output logic                     irq_valid_o,
    input  logic                     irq_ready_i,
    output logic [IdW-1:0]           irq_id_o,
    output logic [LevelW-1:0]        irq_level_o,
    output logic                     irq_shv_o,
    output logic [1:0]               irq_priv_o,
    output logic                     irq_kill_req_o,
    input  logic                     irq_kill_ack_i,
    output logic [NumIrq-1:0]        edge_clear_o
);

    localparam clic_req_t HeldRst = '{id: '0, level: '0, shv: 1'b0, priv: PRIV_M};

    clic_state_e       state_q, state_n;
    clic_req_t         held_q, held_n;
    logic              held_edge_q, held_edge_n;
    logic              valid_q, valid_n;
    logic              kill_q, kill_n;
    logic [NumIrq-1:0] elig;
    logic              best_valid;
    clic_req_t         best;
    logic              held_elig;
    logic              preempt;
    logic              accept;
    logic              unused_held;

    clic_irq_arb #(
        .NumIrq (NumIrq),
        .LevelW (LevelW)
    ) u_arb (
        .pending    (irq_pending_i),
        .enable     (irq_enable_i),
        .level      (irq_level_i),
        .shv        (irq_shv_i),
        .mode       (irq_mode_i),
        .thresh     (irq_thresh_i),
        .elig       (elig),
        .best_valid (best_valid),
        .best       (best)
    );

    assign held_elig = elig[held_q.id[IdW-1:0]];
`ifdef CLIC_IRQ_PRIV_EN
    assign preempt   = best_valid && ((best.priv > held_q.priv) || (best.level > held_q.level));
`else
    assign preempt   = best_valid && (best.level > held_q.level);
`endif
    assign accept    = ((state_q == REQ) || (state_q == KILL)) && irq_ready_i;

    // State and held-request registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            held_q      <= HeldRst;
            held_edge_q <= 1'b0;
            valid_q     <= 1'b0;
            kill_q      <= 1'b0;
        end else begin
            state_q     <= state_n;
            held_q      <= held_n;
            held_edge_q <= held_edge_n;
            valid_q     <= valid_n;
            kill_q      <= kill_n;
        end
    end

    // Next state: capture in IDLE, accept wins over kill, kill waits for ack or a late accept.
    always_comb begin
        state_n     = state_q;
        held_n      = held_q;
        held_edge_n = held_edge_q;
        valid_n     = valid_q;
        kill_n      = kill_q;
        case (state_q)
            IDLE: begin
                if (best_valid) begin
                    held_n      = best;
                    held_edge_n = irq_edge_i[best.id[IdW-1:0]];
                    valid_n     = 1'b1;
                    state_n     = REQ;
                end
            end
            REQ: begin
                if (irq_ready_i) begin
                    valid_n = 1'b0;
                    state_n = IDLE;
                end else if (!held_elig || preempt) begin
                    kill_n  = 1'b1;
                    state_n = KILL;
                end
            end
            KILL: begin
                if (irq_ready_i || irq_kill_ack_i) begin
                    valid_n = 1'b0;
                    kill_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Clear pulse lands in the handshake cycle so the register file drops pending before re-arbitration.
    always_comb begin
        edge_clear_o = '0;
        if (accept && held_edge_q) begin
            edge_clear_o[held_q.id[IdW-1:0]] = 1'b1;
        end
    end

    assign irq_valid_o    = valid_q;
    assign irq_kill_req_o = kill_q;
    assign irq_id_o       = held_q.id[IdW-1:0];
    assign irq_level_o    = held_q.level[LevelW-1:0];
    assign irq_shv_o      = held_q.shv;
`ifdef CLIC_IRQ_PRIV_EN
    assign irq_priv_o     = held_q.priv;
`else
    assign irq_priv_o     = PRIV_M;
`endif
    assign unused_held    = ^{held_q.id, held_q.level, held_q.priv};

endmodule

// File: tb/tb_clic_irq_tx.sv
// Directed self-checking bench for clic_irq_tx (NumIrq=64, LevelW=8).
module tb_clic_irq_tx;

    logic         clk_i;
    logic         rst_ni;
    logic [63:0]  pend;
    logic [63:0]  en;
    logic [511:0] lvl;
    logic [63:0]  shv;
    logic [63:0]  edg;
    logic [127:0] mode;
    logic [7:0]   thresh;
    logic         ready;
    logic         kill_ack;

    logic         valid;
    logic [5:0]   id;
    logic [7:0]   level;
    logic         shv_o;
    logic [1:0]   priv;
    logic         kill_req;
    logic [63:0]  edge_clear;

    int total = 0;
    int bad   = 0;

    clic_irq_tx #(.NumIrq(64), .LevelW(8)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .irq_pending_i  (pend),
        .irq_enable_i   (en),
        .irq_level_i    (lvl),
        .irq_shv_i      (shv),
        .irq_edge_i     (edg),
        .irq_mode_i     (mode),
        .irq_thresh_i   (thresh),
        .irq_valid_o    (valid),
        .irq_ready_i    (ready),
        .irq_id_o       (id),
        .irq_level_o    (level),
        .irq_shv_o      (shv_o),
        .irq_priv_o     (priv),
        .irq_kill_req_o (kill_req),
        .irq_kill_ack_i (kill_ack),
        .edge_clear_o   (edge_clear)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_src(input int s, input logic [7:0] l, input logic e);
        pend[s]       = 1'b1;
        en[s]         = 1'b1;
        lvl[s*8 +: 8] = l;
        edg[s]        = e;
    endtask

    task automatic clear_all();
        pend = '0; en = '0; lvl = '0; shv = '0; edg = '0; mode = '0;
        thresh = '0; ready = 1'b0; kill_ack = 1'b0;
    endtask

    task automatic test_reset();
        clear_all();
        rst_ni = 1'b0;
        #2;
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h exp=0", valid); end
        total++; if (kill_req !== 1'b0) begin bad++; $display("FAIL reset_kill got=%0h exp=0", kill_req); end
        total++; if (edge_clear !== 64'h0) begin bad++; $display("FAIL reset_edge_clear got=%0h exp=0", edge_clear); end
        total++; if ({id, level, shv_o} !== 15'h0) begin bad++; $display("FAIL reset_fields got=%0h exp=0", {id, level, shv_o}); end
        total++; if (priv !== 2'b11) begin bad++; $display("FAIL reset_priv got=%0h exp=3", priv); end
        tick(); tick();
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_single();
        set_src(5, 8'h40, 1'b1);
        shv[5] = 1'b1;
        #1;
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL single_latency got=%0h exp=0", valid); end
        tick();
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0h exp=1", valid); end
        total++; if (id !== 6'd5) begin bad++; $display("FAIL single_id got=%0d exp=5", id); end
        total++; if (level !== 8'h40) begin bad++; $display("FAIL single_level got=%0h exp=40", level); end
        total++; if (shv_o !== 1'b1) begin bad++; $display("FAIL single_shv got=%0h exp=1", shv_o); end
        ready = 1'b1;
        #1;
        total++; if (edge_clear !== (64'd1 << 5)) begin bad++; $display("FAIL single_edge_clear got=%0h exp=%0h", edge_clear, 64'd1 << 5); end
        tick();
        ready = 1'b0; pend[5] = 1'b0; shv[5] = 1'b0;
        #1;
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL single_valid_drop got=%0h exp=0", valid); end
        total++; if (edge_clear !== 64'h0) begin bad++; $display("FAIL single_clear_once got=%0h exp=0", edge_clear); end
        tick();
        clear_all();
    endtask

    task automatic test_tie();
        set_src(3, 8'h80, 1'b0);
        set_src(9, 8'h80, 1'b0);
        set_src(12, 8'h10, 1'b0);
        tick();
        total++; if ({valid, id} !== {1'b1, 6'd3}) begin bad++; $display("FAIL tie_first got=%0h exp=%0h", {valid, id}, {1'b1, 6'd3}); end
        ready = 1'b1;
        #1;
        total++; if (edge_clear !== 64'h0) begin bad++; $display("FAIL tie_level_no_clear got=%0h exp=0", edge_clear); end
        tick();
        ready = 1'b0; pend[3] = 1'b0;
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL tie_idle_gap got=%0h exp=0", valid); end
        tick();
        total++; if ({valid, id, level} !== {1'b1, 6'd9, 8'h80}) begin bad++; $display("FAIL tie_second got=%0h exp=%0h", {valid, id, level}, {1'b1, 6'd9, 8'h80}); end
        ready = 1'b1;
        tick();
        ready = 1'b0; pend[9] = 1'b0;
        tick();
        total++; if ({valid, id, level} !== {1'b1, 6'd12, 8'h10}) begin bad++; $display("FAIL tie_third got=%0h exp=%0h", {valid, id, level}, {1'b1, 6'd12, 8'h10}); end
        ready = 1'b1;
        tick();
        clear_all();
        tick();
    endtask

    task automatic test_preempt();
        set_src(2, 8'h20, 1'b1);
        tick();
        total++; if ({valid, id} !== {1'b1, 6'd2}) begin bad++; $display("FAIL pre_held got=%0h exp=%0h", {valid, id}, {1'b1, 6'd2}); end
        set_src(7, 8'h90, 1'b0);
        #1;
        total++; if (kill_req !== 1'b0) begin bad++; $display("FAIL pre_kill_early got=%0h exp=0", kill_req); end
        tick();
        total++; if ({valid, kill_req, id} !== {1'b1, 1'b1, 6'd2}) begin bad++; $display("FAIL pre_kill got=%0h exp=%0h", {valid, kill_req, id}, {1'b1, 1'b1, 6'd2}); end
        tick();
        total++; if ({valid, kill_req} !== 2'b11) begin bad++; $display("FAIL pre_kill_hold got=%0h exp=3", {valid, kill_req}); end
        kill_ack = 1'b1;
        #1;
        total++; if (edge_clear !== 64'h0) begin bad++; $display("FAIL pre_no_clear got=%0h exp=0", edge_clear); end
        tick();
        kill_ack = 1'b0;
        total++; if ({valid, kill_req} !== 2'b00) begin bad++; $display("FAIL pre_killed got=%0h exp=0", {valid, kill_req}); end
        tick();
        total++; if ({valid, id, level} !== {1'b1, 6'd7, 8'h90}) begin bad++; $display("FAIL pre_new got=%0h exp=%0h", {valid, id, level}, {1'b1, 6'd7, 8'h90}); end
        ready = 1'b1;
        tick();
        ready = 1'b0; pend[7] = 1'b0;
        tick();
        total++; if ({valid, id} !== {1'b1, 6'd2}) begin bad++; $display("FAIL pre_return got=%0h exp=%0h", {valid, id}, {1'b1, 6'd2}); end
    endtask

    task automatic test_simultaneous();
        set_src(10, 8'hA0, 1'b0);
        tick();
        total++; if (kill_req !== 1'b1) begin bad++; $display("FAIL sim_kill got=%0h exp=1", kill_req); end
        ready = 1'b1; kill_ack = 1'b1;
        #1;
        total++; if (edge_clear !== (64'd1 << 2)) begin bad++; $display("FAIL sim_edge_clear got=%0h exp=%0h", edge_clear, 64'd1 << 2); end
        tick();
        ready = 1'b0; kill_ack = 1'b0; pend[2] = 1'b0;
        total++; if ({valid, kill_req} !== 2'b00) begin bad++; $display("FAIL sim_done got=%0h exp=0", {valid, kill_req}); end
        tick();
        total++; if ({valid, kill_req, id} !== {1'b1, 1'b0, 6'd10}) begin bad++; $display("FAIL sim_next got=%0h exp=%0h", {valid, kill_req, id}, {1'b1, 1'b0, 6'd10}); end
        tick();
        total++; if (kill_req !== 1'b0) begin bad++; $display("FAIL sim_no_kill got=%0h exp=0", kill_req); end
        ready = 1'b1;
        tick();
        clear_all();
        tick();
    endtask

    task automatic test_thresh();
        logic seen;
        set_src(4, 8'h30, 1'b0);
        tick();
        total++; if ({valid, id} !== {1'b1, 6'd4}) begin bad++; $display("FAIL thr_held got=%0h exp=%0h", {valid, id}, {1'b1, 6'd4}); end
        thresh = 8'h30;
        tick();
        total++; if ({valid, kill_req} !== 2'b11) begin bad++; $display("FAIL thr_kill got=%0h exp=3", {valid, kill_req}); end
        kill_ack = 1'b1;
        tick();
        kill_ack = 1'b0;
        pend[20] = 1'b1; lvl[20*8 +: 8] = 8'hF0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            seen = seen | valid;
            tick();
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL thr_never got=%0h exp=0", seen); end
        clear_all();
        tick();
    endtask

    task automatic test_reset_mid();
        set_src(8, 8'h55, 1'b1);
        tick();
        total++; if ({valid, id} !== {1'b1, 6'd8}) begin bad++; $display("FAIL rst_held got=%0h exp=%0h", {valid, id}, {1'b1, 6'd8}); end
        ready = 1'b1;
        rst_ni = 1'b0;
        #1;
        total++; if ({valid, kill_req, edge_clear} !== 66'h0) begin bad++; $display("FAIL rst_mid_outs got=%0h exp=0", {valid, kill_req, edge_clear}); end
        total++; if (priv !== 2'b11) begin bad++; $display("FAIL rst_mid_priv got=%0h exp=3", priv); end
        ready = 1'b0;
        tick();
        rst_ni = 1'b1;
        #1;
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL rst_release got=%0h exp=0", valid); end
        tick();
        total++; if ({valid, id, level} !== {1'b1, 6'd8, 8'h55}) begin bad++; $display("FAIL rst_represent got=%0h exp=%0h", {valid, id, level}, {1'b1, 6'd8, 8'h55}); end
        ready = 1'b1;
        tick();
        clear_all();
        tick();
    endtask

`ifdef CLIC_IRQ_PRIV_EN
    task automatic test_priv();
        set_src(1, 8'hFF, 1'b0); mode[1*2 +: 2] = 2'b01;
        set_src(6, 8'h01, 1'b0); mode[6*2 +: 2] = 2'b11;
        tick();
        total++; if ({valid, id, priv} !== {1'b1, 6'd6, 2'b11}) begin bad++; $display("FAIL priv_order got=%0h exp=%0h", {valid, id, priv}, {1'b1, 6'd6, 2'b11}); end
        ready = 1'b1;
        tick();
        clear_all();
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_preempt();
        test_simultaneous();
        test_thresh();
        test_reset_mid();
`ifdef CLIC_IRQ_PRIV_EN
        test_priv();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
